// File: rtl/mmcm_ps_sequencer.sv
// MMCM fine phase-shift sequencer: one PSEN per step, PSDONE handshake, bounded position.
// Build option: define MMCM_PS_TIMEOUT_EN to abort a step whose PSDONE never arrives.
module mmcm_ps_sequencer #(
  parameter int unsigned STEPS_W   = 16,
  parameter int unsigned POS_W     = 16,
  parameter int unsigned POS_LIMIT = 1120,
  parameter int unsigned GAP_CYC   = 4
`ifdef MMCM_PS_TIMEOUT_EN
  ,
  parameter int unsigned TMO_CYC   = 64
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               mmcm_locked,
  output logic               psen,
  output logic               psincdec,
  input  logic               psdone,
  output logic               busy,
  output logic               done,
  output logic               clipped,
  output logic               aborted,
  output logic [POS_W-1:0]   pos
);

  localparam int unsigned MagW = STEPS_W + 1;
  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic signed [POS_W-1:0] PosMax = POS_W'(POS_LIMIT);
  localparam logic signed [POS_W-1:0] PosMin = -PosMax;
  localparam logic signed [POS_W-1:0] PosOne = POS_W'(1);
`ifdef MMCM_PS_TIMEOUT_EN
  localparam int unsigned TmoW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

  state_e                  state_q;
  logic [MagW-1:0]         rem_q;
  logic [GapW-1:0]         gap_q;
  logic signed [POS_W-1:0] pos_q;
  logic                    ready_en_q, lost_q;
  logic                    psen_q, psincdec_q, busy_q, done_q, clipped_q, aborted_q;
`ifdef MMCM_PS_TIMEOUT_EN
  logic [TmoW-1:0]         tmo_q;
`endif

  logic [MagW-1:0]         steps_ext, steps_mag;
  logic signed [POS_W-1:0] pos_eff;
  logic                    accept, step_dir, gap_last, clip_hit, wait_step, step_now;

  // Sign-extend one bit first so the most-negative command has a representable magnitude.
  always_comb begin
    steps_ext = {cmd_steps[STEPS_W-1], cmd_steps};
    steps_mag = steps_ext[MagW-1] ? (~steps_ext + MagW'(1)) : steps_ext;
  end

  assign cmd_ready = (state_q == StIdle) && ready_en_q && mmcm_locked;
  assign accept    = cmd_valid && cmd_ready;
  assign gap_last  = (gap_q == GapW'(GAP_CYC - 1));

  // Position as it stands after this cycle's PSDONE, so back-to-back issue checks the new value.
  assign pos_eff  = (state_q == StWait && psdone) ?
                    pos_q + (psincdec_q ? PosOne : -PosOne) : pos_q;
  assign step_dir = (state_q == StIdle) ? ~cmd_steps[STEPS_W-1] : psincdec_q;
  assign clip_hit = step_dir ? (pos_eff >= PosMax) : (pos_eff <= PosMin);

  assign wait_step = (state_q == StWait) && psdone && (rem_q != MagW'(1)) && !lost_q &&
                     mmcm_locked && (GAP_CYC == 0);
  assign step_now  = (accept && (steps_mag != '0)) || wait_step ||
                     ((state_q == StGap) && mmcm_locked && gap_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      gap_q      <= '0;
      pos_q      <= '0;
      ready_en_q <= 1'b0;
      lost_q     <= 1'b0;
      psen_q     <= 1'b0;
      psincdec_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clipped_q  <= 1'b0;
      aborted_q  <= 1'b0;
`ifdef MMCM_PS_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      ready_en_q <= 1'b1;
      psen_q     <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (accept) begin
            busy_q     <= 1'b1;
            clipped_q  <= 1'b0;
            aborted_q  <= 1'b0;
            psincdec_q <= ~cmd_steps[STEPS_W-1];
            rem_q      <= steps_mag;
            done_q     <= (steps_mag == '0);
          end
        end
        StIssue: begin
          state_q <= StWait;
          lost_q  <= 1'b0;
`ifdef MMCM_PS_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        StWait: begin
          // A lock loss here cannot cancel the step in flight; it ends the command afterwards.
          if (!mmcm_locked) lost_q <= 1'b1;
          if (psdone) begin
            pos_q <= pos_eff;
            rem_q <= rem_q - MagW'(1);
            if (rem_q == MagW'(1)) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else if (lost_q || !mmcm_locked) begin
              aborted_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= StIdle;
            end else if (GAP_CYC != 0) begin
              state_q <= StGap;
              gap_q   <= '0;
            end
          end
`ifdef MMCM_PS_TIMEOUT_EN
          else if (tmo_q == TmoW'(TMO_CYC - 1)) begin
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= StIdle;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
`endif
        end
        StGap: begin
          if (!mmcm_locked) begin
            aborted_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= StIdle;
          end else if (!gap_last) begin
            gap_q <= gap_q + GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
      if (step_now) begin
        if (clip_hit) begin
          clipped_q <= 1'b1;
          done_q    <= 1'b1;
          state_q   <= StIdle;
        end else begin
          psen_q  <= 1'b1;
          state_q <= StIssue;
        end
      end
    end
  end

  assign psen     = psen_q;
  assign psincdec = psincdec_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign clipped  = clipped_q;
  assign aborted  = aborted_q;
  assign pos      = pos_q;

endmodule
